idex_operand_stage: RTL and testbench

//  ID/EX pipeline register plus execute-stage operand forwarding, directly upstream of the ALU.

---
 rtl/idex_operand_stage.sv | 109 ++++++++++
 tb/tb_idex_operand_stage.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/idex_operand_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding feeding the ALU,
// plus load-use hazard detection for the decode-stage stall logic.
module idex_operand_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall_e,
  input  logic                  flush_e,
  input  logic                  valid_d,
  input  logic [DATA_W-1:0]     rd1_d,
  input  logic [DATA_W-1:0]     rd2_d,
  input  logic [DATA_W-1:0]     signimm_d,
  input  logic [REG_ADDR_W-1:0] rs_d,
  input  logic [REG_ADDR_W-1:0] rt_d,
  input  logic [REG_ADDR_W-1:0] rd_d,
  input  logic [2:0]            alucontrol_d,
  input  logic                  alusrc_d,
  input  logic                  regdst_d,
  input  logic                  regwrite_d,
  input  logic                  memtoreg_d,
  input  logic                  memwrite_d,
  input  logic [REG_ADDR_W-1:0] writereg_m,
  input  logic                  regwrite_m,
  input  logic [DATA_W-1:0]     aluout_m,
  input  logic [REG_ADDR_W-1:0] writereg_w,
  input  logic                  regwrite_w,
  input  logic [DATA_W-1:0]     result_w,
  output logic [DATA_W-1:0]     srca_e,
  output logic [DATA_W-1:0]     srcb_e,
  output logic [2:0]            alucont_e,
  output logic [DATA_W-1:0]     writedata_e,
  output logic [REG_ADDR_W-1:0] writereg_e,
  output logic                  regwrite_e,
  output logic                  memtoreg_e,
  output logic                  memwrite_e,
  output logic                  valid_e,
  output logic                  lwstall_d
);

  localparam logic [2:0] ALU_ADD = 3'b010;

  logic                  alusrc_e;
  logic                  regdst_e;
  logic [DATA_W-1:0]     rd1_e;
  logic [DATA_W-1:0]     rd2_e;
  logic [DATA_W-1:0]     imm_e;
  logic [REG_ADDR_W-1:0] rs_e;
  logic [REG_ADDR_W-1:0] rt_e;
  logic [REG_ADDR_W-1:0] rd_e;
  logic [DATA_W-1:0]     fwd_a;
  logic [DATA_W-1:0]     fwd_b;

  // Register zero is hardwired, so it is never a forwarding target.
  always_comb begin
    fwd_a = rd1_e;
    if (rs_e != '0 && regwrite_m && writereg_m == rs_e)      fwd_a = aluout_m;
    else if (rs_e != '0 && regwrite_w && writereg_w == rs_e) fwd_a = result_w;
    fwd_b = rd2_e;
    if (rt_e != '0 && regwrite_m && writereg_m == rt_e)      fwd_b = aluout_m;
    else if (rt_e != '0 && regwrite_w && writereg_w == rt_e) fwd_b = result_w;
  end

  always_ff @(posedge clk) begin
    if (reset || flush_e) begin
      valid_e    <= 1'b0;
      regwrite_e <= 1'b0;
      memtoreg_e <= 1'b0;
      memwrite_e <= 1'b0;
      alusrc_e   <= 1'b0;
      regdst_e   <= 1'b0;
      alucont_e  <= ALU_ADD;
      rd1_e      <= '0;
      rd2_e      <= '0;
      imm_e      <= '0;
      rs_e       <= '0;
      rt_e       <= '0;
      rd_e       <= '0;
    end else if (stall_e) begin
      // Capture forwarded values so a producer leaving WB mid-stall is kept.
      rd1_e <= fwd_a;
      rd2_e <= fwd_b;
    end else begin
      valid_e    <= valid_d;
      regwrite_e <= valid_d & regwrite_d;
      memtoreg_e <= valid_d & memtoreg_d;
      memwrite_e <= valid_d & memwrite_d;
      alusrc_e   <= valid_d & alusrc_d;
      regdst_e   <= valid_d & regdst_d;
      alucont_e  <= valid_d ? alucontrol_d : ALU_ADD;
      rd1_e      <= rd1_d;
      rd2_e      <= rd2_d;
      imm_e      <= signimm_d;
      rs_e       <= rs_d;
      rt_e       <= rt_d;
      rd_e       <= rd_d;
    end
  end

  assign srca_e      = fwd_a;
  assign writedata_e = fwd_b;
  assign srcb_e      = alusrc_e ? imm_e : fwd_b;
  assign writereg_e  = regdst_e ? rd_e : rt_e;

  assign lwstall_d = ~reset & valid_e & memtoreg_e & (rt_e != '0) &
                     ((rt_e == rs_d) | (rt_e == rt_d));

endmodule

// File: tb/tb_idex_operand_stage.sv
// Bench for idex_operand_stage: directed scenarios plus randomized run against
// an instruction-level model of the EX slot.
module tb_idex_operand_stage;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset, stall_e, flush_e, valid_d;
  logic [DW-1:0] rd1_d, rd2_d, signimm_d, aluout_m, result_w;
  logic [AW-1:0] rs_d, rt_d, rd_d, writereg_m, writereg_w;
  logic [2:0]    alucontrol_d;
  logic          alusrc_d, regdst_d, regwrite_d, memtoreg_d, memwrite_d;
  logic          regwrite_m, regwrite_w;
  logic [DW-1:0] srca_e, srcb_e, writedata_e;
  logic [2:0]    alucont_e;
  logic [AW-1:0] writereg_e;
  logic          regwrite_e, memtoreg_e, memwrite_e, valid_e, lwstall_d;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  idex_operand_stage #(.DATA_W(DW), .REG_ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .stall_e(stall_e), .flush_e(flush_e),
    .valid_d(valid_d), .rd1_d(rd1_d), .rd2_d(rd2_d), .signimm_d(signimm_d),
    .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d), .alucontrol_d(alucontrol_d),
    .alusrc_d(alusrc_d), .regdst_d(regdst_d), .regwrite_d(regwrite_d),
    .memtoreg_d(memtoreg_d), .memwrite_d(memwrite_d),
    .writereg_m(writereg_m), .regwrite_m(regwrite_m), .aluout_m(aluout_m),
    .writereg_w(writereg_w), .regwrite_w(regwrite_w), .result_w(result_w),
    .srca_e(srca_e), .srcb_e(srcb_e), .alucont_e(alucont_e),
    .writedata_e(writedata_e), .writereg_e(writereg_e),
    .regwrite_e(regwrite_e), .memtoreg_e(memtoreg_e), .memwrite_e(memwrite_e),
    .valid_e(valid_e), .lwstall_d(lwstall_d)
  );

  // Model of the instruction sitting in EX.
  logic          m_valid, m_rw, m_mtr, m_mw, m_alusrc, m_regdst;
  logic [2:0]    m_alu;
  logic [DW-1:0] m_a, m_b, m_imm;
  logic [AW-1:0] m_rs, m_rt, m_rd;

  // Value of architectural register src as seen by EX: the youngest in-flight producer wins.
  function automatic logic [DW-1:0] operand(input logic [AW-1:0] src, input logic [DW-1:0] latched);
    if (src == 0) return latched;
    if (regwrite_m && writereg_m == src) return aluout_m;
    if (regwrite_w && writereg_w == src) return result_w;
    return latched;
  endfunction

  task automatic tick();
    logic [DW-1:0] a, b;
    a = operand(m_rs, m_a);
    b = operand(m_rt, m_b);
    if (reset || flush_e) begin
      {m_valid, m_rw, m_mtr, m_mw, m_alusrc, m_regdst} = '0;
      m_alu = 3'b010; m_a = 0; m_b = 0; m_imm = 0; m_rs = 0; m_rt = 0; m_rd = 0;
    end else if (stall_e) begin
      m_a = a; m_b = b;
    end else begin
      m_valid = valid_d; m_rw = valid_d & regwrite_d; m_mtr = valid_d & memtoreg_d;
      m_mw = valid_d & memwrite_d; m_alusrc = valid_d & alusrc_d; m_regdst = valid_d & regdst_d;
      m_alu = alucontrol_d; m_a = rd1_d; m_b = rd2_d; m_imm = signimm_d;
      m_rs = rs_d; m_rt = rt_d; m_rd = rd_d;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    reset = 0; stall_e = 0; flush_e = 0; valid_d = 0;
    rd1_d = 0; rd2_d = 0; signimm_d = 0; rs_d = 0; rt_d = 0; rd_d = 0;
    alucontrol_d = 3'b010; alusrc_d = 0; regdst_d = 0; regwrite_d = 0;
    memtoreg_d = 0; memwrite_d = 0;
    writereg_m = 0; regwrite_m = 0; aluout_m = 0;
    writereg_w = 0; regwrite_w = 0; result_w = 0;
  endtask

  task automatic randomize_inputs();
    valid_d = $urandom_range(0, 3) != 0;
    rd1_d = $urandom; rd2_d = $urandom; signimm_d = $urandom;
    rs_d = AW'($urandom_range(0, 3)); rt_d = AW'($urandom_range(0, 3)); rd_d = AW'($urandom_range(0, 3));
    alucontrol_d = 3'($urandom); alusrc_d = 1'($urandom); regdst_d = 1'($urandom);
    regwrite_d = 1'($urandom); memtoreg_d = 1'($urandom); memwrite_d = 1'($urandom);
    writereg_m = AW'($urandom_range(0, 3)); regwrite_m = 1'($urandom); aluout_m = $urandom;
    writereg_w = AW'($urandom_range(0, 3)); regwrite_w = 1'($urandom); result_w = $urandom;
  endtask

  task automatic load_instr(input logic [AW-1:0] rs, input logic [AW-1:0] rt, input logic [AW-1:0] rd,
                            input logic [DW-1:0] a, input logic [DW-1:0] b,
                            input logic rw, input logic mtr, input logic mw, input logic rdst);
    valid_d = 1; rs_d = rs; rt_d = rt; rd_d = rd; rd1_d = a; rd2_d = b; signimm_d = 32'h1234;
    alucontrol_d = 3'b010; alusrc_d = 0; regdst_d = rdst;
    regwrite_d = rw; memtoreg_d = mtr; memwrite_d = mw;
    tick();
    valid_d = 0;
  endtask

  task automatic test_reset();
    randomize_inputs();
    reset = 1; stall_e = 1'($urandom); flush_e = 1'($urandom);
    tick();
    randomize_inputs();
    tick();
    n_tests++;
    if ({valid_e, regwrite_e, memtoreg_e, memwrite_e} !== 4'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 0000", {valid_e, regwrite_e, memtoreg_e, memwrite_e});
    end
    n_tests++;
    if (alucont_e !== 3'b010) begin n_fail++; $display("FAIL reset_alucont: got %b want 010", alucont_e); end
    n_tests++;
    if (srca_e !== 0 || srcb_e !== 0) begin
      n_fail++; $display("FAIL reset_src: srca %h srcb %h want 0", srca_e, srcb_e);
    end
    n_tests++;
    if (lwstall_d !== 1'b0) begin n_fail++; $display("FAIL reset_lwstall: got %b want 0", lwstall_d); end
    clear_inputs();
  endtask

  task automatic test_load();
    load_instr(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 1'b1, 1'b0, 1'b0, 1'b1);
    n_tests++;
    if (srca_e !== 32'd5 || srcb_e !== 32'd7 || alucont_e !== 3'b010) begin
      n_fail++; $display("FAIL load_ops: srca %0d srcb %0d alu %b want 5 7 010", srca_e, srcb_e, alucont_e);
    end
    n_tests++;
    if (writereg_e !== 5'd3 || regwrite_e !== 1'b1 || valid_e !== 1'b1) begin
      n_fail++; $display("FAIL load_ctrl: writereg %0d rw %b valid %b want 3 1 1", writereg_e, regwrite_e, valid_e);
    end
  endtask

  task automatic test_fwd_priority();
    load_instr(5'd3, 5'd0, 5'd0, 32'h99, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    regwrite_m = 1; writereg_m = 3; aluout_m = 32'h11;
    regwrite_w = 1; writereg_w = 3; result_w = 32'h22;
    #1;
    n_tests++;
    if (srca_e !== 32'h11) begin n_fail++; $display("FAIL fwd_mem_wins: got %h want 11", srca_e); end
    regwrite_m = 0; #1;
    n_tests++;
    if (srca_e !== 32'h22) begin n_fail++; $display("FAIL fwd_wb: got %h want 22", srca_e); end
    regwrite_w = 0; #1;
    n_tests++;
    if (srca_e !== 32'h99) begin n_fail++; $display("FAIL fwd_none: got %h want 99", srca_e); end
    clear_inputs();
    load_instr(5'd0, 5'd0, 5'd0, 32'h44, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    regwrite_m = 1; writereg_m = 0; aluout_m = 32'h11;
    regwrite_w = 1; writereg_w = 0; result_w = 32'h22;
    #1;
    n_tests++;
    if (srca_e !== 32'h44) begin n_fail++; $display("FAIL fwd_r0: got %h want 44", srca_e); end
    clear_inputs();
  endtask

  task automatic test_stall_retire();
    load_instr(5'd0, 5'd4, 5'd0, 32'h0, 32'h01, 1'b1, 1'b0, 1'b0, 1'b0);
    regwrite_w = 1; writereg_w = 4; result_w = 32'h55;
    #1;
    n_tests++;
    if (srcb_e !== 32'h55 || writedata_e !== 32'h55) begin
      n_fail++; $display("FAIL stall_pre: srcb %h wd %h want 55", srcb_e, writedata_e);
    end
    stall_e = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      regwrite_w = 0; result_w = 32'hdead;
      n_tests++;
      if (srcb_e !== 32'h55) begin n_fail++; $display("FAIL stall_hold%0d: got %h want 55", i, srcb_e); end
    end
    stall_e = 0; #1;
    n_tests++;
    if (srcb_e !== 32'h55 || writedata_e !== 32'h55) begin
      n_fail++; $display("FAIL stall_release: srcb %h wd %h want 55", srcb_e, writedata_e);
    end
    clear_inputs();
  endtask

  task automatic test_load_use();
    load_instr(5'd1, 5'd8, 5'd0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    rs_d = 8; rt_d = 0; #1;
    n_tests++;
    if (lwstall_d !== 1'b1) begin n_fail++; $display("FAIL lw_rs: got %b want 1", lwstall_d); end
    rs_d = 0; rt_d = 8; #1;
    n_tests++;
    if (lwstall_d !== 1'b1) begin n_fail++; $display("FAIL lw_rt: got %b want 1", lwstall_d); end
    rs_d = 1; rt_d = 2; #1;
    n_tests++;
    if (lwstall_d !== 1'b0) begin n_fail++; $display("FAIL lw_nodep: got %b want 0", lwstall_d); end
    load_instr(5'd1, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    rs_d = 0; rt_d = 0; #1;
    n_tests++;
    if (lwstall_d !== 1'b0) begin n_fail++; $display("FAIL lw_r0: got %b want 0", lwstall_d); end
    load_instr(5'd1, 5'd8, 5'd0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    rs_d = 8; flush_e = 1;
    tick();
    flush_e = 0;
    n_tests++;
    if (valid_e !== 1'b0 || regwrite_e !== 1'b0 || lwstall_d !== 1'b0) begin
      n_fail++; $display("FAIL lw_flush: valid %b rw %b lwstall %b want 0 0 0", valid_e, regwrite_e, lwstall_d);
    end
    load_instr(5'd1, 5'd8, 5'd0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    rs_d = 8; reset = 1; stall_e = 1; #1;
    n_tests++;
    if (lwstall_d !== 1'b0) begin n_fail++; $display("FAIL lw_in_reset: got %b want 0", lwstall_d); end
    tick();
    reset = 0; stall_e = 0; #1;
    n_tests++;
    if (valid_e !== 1'b0 || lwstall_d !== 1'b0) begin
      n_fail++; $display("FAIL lw_after_reset: valid %b lwstall %b want 0 0", valid_e, lwstall_d);
    end
    clear_inputs();
  endtask

  task automatic test_flush_vs_stall();
    load_instr(5'd2, 5'd3, 5'd0, 32'h77, 32'h88, 1'b0, 1'b0, 1'b1, 1'b0);
    n_tests++;
    if (memwrite_e !== 1'b1 || valid_e !== 1'b1) begin
      n_fail++; $display("FAIL fs_pre: memwrite %b valid %b want 1 1", memwrite_e, valid_e);
    end
    flush_e = 1; stall_e = 1;
    tick();
    flush_e = 0; stall_e = 0;
    n_tests++;
    if (memwrite_e !== 1'b0 || valid_e !== 1'b0 || srca_e !== 0 || alucont_e !== 3'b010) begin
      n_fail++; $display("FAIL fs_bubble: memwrite %b valid %b srca %h alu %b want 0 0 0 010",
                         memwrite_e, valid_e, srca_e, alucont_e);
    end
    clear_inputs();
  endtask

  task automatic test_random();
    logic [DW-1:0] exp_a, exp_b, exp_srcb;
    logic          exp_lw;
    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      reset   = $urandom_range(0, 39) == 0;
      flush_e = $urandom_range(0, 9) == 0;
      stall_e = $urandom_range(0, 4) == 0;
      #1;
      exp_a    = operand(m_rs, m_a);
      exp_b    = operand(m_rt, m_b);
      exp_srcb = m_alusrc ? m_imm : exp_b;
      exp_lw   = !reset && m_valid && m_mtr && m_rt != 0 && (m_rt == rs_d || m_rt == rt_d);
      n_tests++;
      if (srca_e !== exp_a || writedata_e !== exp_b || lwstall_d !== exp_lw ||
          {valid_e, regwrite_e, memtoreg_e, memwrite_e} !== {m_valid, m_rw, m_mtr, m_mw} ||
          (m_valid && (srcb_e !== exp_srcb || alucont_e !== m_alu ||
                       writereg_e !== (m_regdst ? m_rd : m_rt)))) begin
        n_fail++;
        $display("FAIL random[%0d]: srca %h/%h wd %h/%h srcb %h/%h alu %b/%b wr %0d lw %b/%b ctl %b/%b",
                 i, srca_e, exp_a, writedata_e, exp_b, srcb_e, exp_srcb, alucont_e, m_alu,
                 writereg_e, lwstall_d, exp_lw, {valid_e, regwrite_e, memtoreg_e, memwrite_e},
                 {m_valid, m_rw, m_mtr, m_mw});
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_load();
    test_fwd_priority();
    test_stall_retire();
    test_load_use();
    test_flush_vs_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
